// File: rtl/one_hot_iterator_if.sv
// Handshake bundle for one_hot_iterator: vector input side and one-hot beat output side.
interface one_hot_iterator_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned INDEX_WIDTH = $clog2(WIDTH);

  logic                   data_valid;
  logic                   data_ready;
  logic [WIDTH-1:0]       data;
  logic                   one_hot_valid;
  logic                   one_hot_ready;
  logic [WIDTH-1:0]       one_hot;
  logic [INDEX_WIDTH-1:0] index;
  logic                   last;
  logic                   empty;

  // Producer of vectors and consumer of beats
  modport master (
    output data_valid, data, one_hot_ready,
    input  data_ready, one_hot_valid, one_hot, index, last, empty
  );

  // The iterator itself
  modport slave (
    input  data_valid, data, one_hot_ready,
    output data_ready, one_hot_valid, one_hot, index, last, empty
  );
endinterface

// File: rtl/one_hot_iterator.sv
// Drains a multi-bit vector as a stream of one-hot beats, lowest set bit first,
// with binary index, last and empty flags; beat outputs come straight from flops.
module one_hot_iterator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clock,
  input  logic              resetn,
  one_hot_iterator_if.slave bus
);
  localparam int unsigned INDEX_WIDTH = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       remaining_q, remaining_d;
  logic                   zero_q, zero_d;
  logic                   one_hot_valid_q, one_hot_valid_d;
  logic [WIDTH-1:0]       one_hot_q, one_hot_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   last_q, last_d;
  logic                   empty_q, empty_d;

  logic                   data_ready_c;
  logic                   xfer_c;
  logic                   accept_c;

  // Next state plus the beat that the next state will present
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    zero_d          = zero_q;
    one_hot_valid_d = 1'b0;
    one_hot_d       = '0;
    index_d         = '0;
    last_d          = 1'b0;
    empty_d         = 1'b0;

    xfer_c       = one_hot_valid_q & bus.one_hot_ready;
    data_ready_c = (state_q == IDLE) | (xfer_c & last_q);
    accept_c     = bus.data_valid & data_ready_c;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          remaining_d = bus.data;
          zero_d      = (bus.data == '0);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (xfer_c) begin
          if (!last_q) begin
            remaining_d = remaining_q & ~one_hot_q;
          end else if (accept_c) begin
            remaining_d = bus.data;
            zero_d      = (bus.data == '0);
          end else begin
            remaining_d = '0;
            zero_d      = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Decode ahead of the edge so the beat is registered, not decoded from flops
    if (state_d == BUSY) begin
      one_hot_valid_d = 1'b1;
      one_hot_d       = remaining_d & ~(remaining_d - WIDTH'(1));
      last_d          = (remaining_d & (remaining_d - WIDTH'(1))) == '0;
      empty_d         = zero_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (one_hot_d[i]) index_d = INDEX_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q         <= IDLE;
      remaining_q     <= '0;
      zero_q          <= 1'b0;
      one_hot_valid_q <= 1'b0;
      one_hot_q       <= '0;
      index_q         <= '0;
      last_q          <= 1'b0;
      empty_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      zero_q          <= zero_d;
      one_hot_valid_q <= one_hot_valid_d;
      one_hot_q       <= one_hot_d;
      index_q         <= index_d;
      last_q          <= last_d;
      empty_q         <= empty_d;
    end
  end

  assign bus.data_ready    = data_ready_c;
  assign bus.one_hot_valid = one_hot_valid_q;
  assign bus.one_hot       = one_hot_q;
  assign bus.index         = index_q;
  assign bus.last          = last_q;
  assign bus.empty         = empty_q;
endmodule

// File: tb/tb_one_hot_iterator.sv
// Self-checking bench for one_hot_iterator: directed scenarios plus a random
// stream checked against a queue of expected beats built from each vector's set bits.
module tb_one_hot_iterator;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = $clog2(W);

  typedef struct packed {
    logic [W-1:0]  oh;
    logic [IW-1:0] idx;
    logic          last;
    logic          empty;
  } beat_t;

  localparam beat_t IDLE_BEAT = '{oh: '0, idx: '0, last: 1'b0, empty: 1'b0};

  logic  clock;
  logic  resetn;
  int    n_vec;
  int    n_err;
  beat_t exp_q[$];

  one_hot_iterator_if #(.WIDTH(W)) ifc ();

  one_hot_iterator #(.WIDTH(W)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic beat_t got();
    return {ifc.one_hot, ifc.index, ifc.last, ifc.empty};
  endfunction

  // Reference: one beat per set bit in ascending order; a zero vector is one empty beat
  function automatic void push_vec(input logic [W-1:0] v);
    beat_t b;
    if (v == '0) begin
      b = '{oh: '0, idx: '0, last: 1'b1, empty: 1'b1};
      exp_q.push_back(b);
    end else begin
      for (int unsigned i = 0; i < W; i++) begin
        if (v[i]) begin
          b.oh    = W'(1) << i;
          b.idx   = IW'(i);
          b.last  = (v >> (i + 1)) == '0;
          b.empty = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [W-1:0] d, input logic rdy);
    ifc.data_valid    = dv;
    ifc.data          = d;
    ifc.one_hot_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b1, 8'hFF, 1'b1);
    repeat (3) tick();
    resetn = 1'b1;
    drive(1'b0, '0, 1'b0);
    n_vec++;
    if (ifc.data_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", ifc.data_ready);
    end
    n_vec++;
    if (ifc.one_hot_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", ifc.one_hot_valid);
    end
    n_vec++;
    if (got() !== IDLE_BEAT) begin
      n_err++; $display("FAIL reset_outputs: got %h expected %h", got(), IDLE_BEAT);
    end
    exp_q.delete();
  endtask

  task automatic test_pattern();
    beat_t tbl [3];
    tbl[0] = '{oh: 8'h04, idx: 3'd2, last: 1'b0, empty: 1'b0};
    tbl[1] = '{oh: 8'h20, idx: 3'd5, last: 1'b0, empty: 1'b0};
    tbl[2] = '{oh: 8'h80, idx: 3'd7, last: 1'b1, empty: 1'b0};
    drive(1'b1, 8'hA4, 1'b1);
    n_vec++;
    if (ifc.data_ready !== 1'b1) begin
      n_err++; $display("FAIL pattern_accept: got %b expected 1", ifc.data_ready);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1);
      n_vec++;
      if (ifc.one_hot_valid !== 1'b1 || got() !== tbl[k]) begin
        n_err++; $display("FAIL pattern_beat%0d: got v=%b %h expected v=1 %h", k, ifc.one_hot_valid, got(), tbl[k]);
      end
      n_vec++;
      if (ifc.data_ready !== (k == 2)) begin
        n_err++; $display("FAIL pattern_ready%0d: got %b expected %b", k, ifc.data_ready, (k == 2));
      end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    n_vec++;
    if (ifc.one_hot_valid !== 1'b0) begin
      n_err++; $display("FAIL pattern_idle: got valid %b expected 0", ifc.one_hot_valid);
    end
  endtask

  task automatic test_zero();
    beat_t zb;
    zb = '{oh: '0, idx: '0, last: 1'b1, empty: 1'b1};
    drive(1'b1, 8'h00, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    n_vec++;
    if (ifc.one_hot_valid !== 1'b1 || got() !== zb) begin
      n_err++; $display("FAIL zero_beat: got v=%b %h expected v=1 %h", ifc.one_hot_valid, got(), zb);
    end
    tick();
    drive(1'b0, '0, 1'b1);
    n_vec++;
    if (ifc.one_hot_valid !== 1'b0 || ifc.data_ready !== 1'b1) begin
      n_err++; $display("FAIL zero_idle: got valid %b ready %b expected 0 1", ifc.one_hot_valid, ifc.data_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vecs [2];
    int           ptr;
    logic         dv;
    logic         exp_rdy;
    vecs[0] = 8'h81;
    vecs[1] = 8'hFF;
    exp_q.delete();
    push_vec(vecs[0]);
    push_vec(vecs[1]);
    drive(1'b1, vecs[0], 1'b1);
    tick();
    ptr = 1;
    for (int c = 0; c < 10; c++) begin
      dv = (ptr < 2);
      drive(dv, dv ? vecs[ptr] : '0, 1'b1);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL b2b_model_empty: cycle %0d", c);
      end else begin
        if (ifc.one_hot_valid !== 1'b1 || got() !== exp_q[0]) begin
          n_err++; $display("FAIL b2b_beat%0d: got v=%b %h expected v=1 %h", c, ifc.one_hot_valid, got(), exp_q[0]);
        end
        exp_rdy = exp_q[0].last;
        n_vec++;
        if (ifc.data_ready !== exp_rdy) begin
          n_err++; $display("FAIL b2b_ready%0d: got %b expected %b", c, ifc.data_ready, exp_rdy);
        end
        if (dv && exp_rdy) ptr++;
        void'(exp_q.pop_front());
      end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    n_vec++;
    if (ifc.one_hot_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: got valid %b expected 0", ifc.one_hot_valid);
    end
  endtask

  task automatic test_backpressure();
    logic rdy_seq [5];
    logic exp_rdy;
    rdy_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_q.delete();
    push_vec(8'h12);
    drive(1'b1, 8'h12, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 8'h55, rdy_seq[c]);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL bp_model_empty: cycle %0d", c);
      end else begin
        if (ifc.one_hot_valid !== 1'b1 || got() !== exp_q[0]) begin
          n_err++; $display("FAIL bp_beat%0d: got v=%b %h expected v=1 %h", c, ifc.one_hot_valid, got(), exp_q[0]);
        end
        exp_rdy = rdy_seq[c] & exp_q[0].last;
        n_vec++;
        if (ifc.data_ready !== exp_rdy) begin
          n_err++; $display("FAIL bp_ready%0d: got %b expected %b", c, ifc.data_ready, exp_rdy);
        end
        if (rdy_seq[c]) void'(exp_q.pop_front());
      end
      if (c == 4) drive(1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    n_vec++;
    if (ifc.one_hot_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_idle: got valid %b expected 0", ifc.one_hot_valid);
    end
  endtask

  task automatic test_reset_midstream();
    beat_t b3;
    b3 = '{oh: 8'h08, idx: 3'd3, last: 1'b1, empty: 1'b0};
    exp_q.delete();
    push_vec(8'hFF);
    drive(1'b1, 8'hFF, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b1);
      n_vec++;
      if (ifc.one_hot_valid !== 1'b1 || got() !== exp_q[0]) begin
        n_err++; $display("FAIL mid_beat%0d: got v=%b %h expected v=1 %h", c, ifc.one_hot_valid, got(), exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
    end
    resetn = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    n_vec++;
    if (ifc.one_hot_valid !== 1'b0 || ifc.data_ready !== 1'b1 || got() !== IDLE_BEAT) begin
      n_err++; $display("FAIL mid_reset: got v=%b r=%b %h expected v=0 r=1 %h", ifc.one_hot_valid, ifc.data_ready, got(), IDLE_BEAT);
    end
    resetn = 1'b1;
    exp_q.delete();
    drive(1'b1, 8'h08, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    n_vec++;
    if (ifc.one_hot_valid !== 1'b1 || got() !== b3) begin
      n_err++; $display("FAIL mid_after: got v=%b %h expected v=1 %h", ifc.one_hot_valid, got(), b3);
    end
    tick();
    drive(1'b0, '0, 1'b1);
    n_vec++;
    if (ifc.one_hot_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_after_idle: got valid %b expected 0", ifc.one_hot_valid);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] cur;
    logic         have;
    logic         dv, rdy, exp_valid, exp_rdy, xfer, acc;
    int           done;
    int           cycles;
    exp_q.delete();
    have   = 1'b0;
    done   = 0;
    cycles = 0;
    cur    = '0;
    while (done < 60 || exp_q.size() != 0) begin
      if (cycles >= 3000) begin
        n_vec++; n_err++;
        $display("FAIL rand_timeout: got %0d vectors expected 60", done);
        break;
      end
      if (!have && done < 60) begin
        case ($urandom_range(0, 5))
          0:       cur = '0;
          1:       cur = '1;
          2:       cur = W'(1) << (W - 1);
          default: cur = W'($urandom);
        endcase
        have = 1'b1;
      end
      dv  = have && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(dv, dv ? cur : W'($urandom), rdy);
      exp_valid = (exp_q.size() != 0);
      n_vec++;
      if (ifc.one_hot_valid !== exp_valid) begin
        n_err++; $display("FAIL rand_valid c%0d: got %b expected %b", cycles, ifc.one_hot_valid, exp_valid);
      end
      if (exp_valid) begin
        n_vec++;
        if (got() !== exp_q[0]) begin
          n_err++; $display("FAIL rand_beat c%0d: got %h expected %h", cycles, got(), exp_q[0]);
        end
        n_vec++;
        if (!($onehot(ifc.one_hot) || (ifc.one_hot == '0 && ifc.empty))) begin
          n_err++; $display("FAIL rand_onehot c%0d: got %h empty %b expected one-hot", cycles, ifc.one_hot, ifc.empty);
        end
      end
      exp_rdy = !exp_valid || (rdy && exp_q[0].last);
      n_vec++;
      if (ifc.data_ready !== exp_rdy) begin
        n_err++; $display("FAIL rand_ready c%0d: got %b expected %b", cycles, ifc.data_ready, exp_rdy);
      end
      xfer = exp_valid && rdy;
      acc  = dv && exp_rdy;
      tick();
      cycles++;
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        push_vec(cur);
        have = 1'b0;
        done++;
      end
    end
    drive(1'b0, '0, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 1'b0;
    ifc.data_valid    = 1'b0;
    ifc.data          = '0;
    ifc.one_hot_ready = 1'b0;
    test_reset();
    test_pattern();
    test_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
